// File: rtl/reset_sequencer.sv
// Staged reset controller: holds downstream units in reset, then releases them one at a
// time in index order, waiting for each stage's ack and faulting on an ack timeout.
`timescale 1ns/1ps

module reset_sequencer #(
    parameter int unsigned NSTAGES     = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 8,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               swreset_req,
    input  logic [NSTAGES-1:0] stage_ack,
    output logic [NSTAGES-1:0] stage_reset,
    output logic               resetting,
    output logic               fault,
    output logic [2:0]         stage_idx
);

    localparam int unsigned MAX_HG  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int unsigned CNT_MAX = (MAX_HG > ACK_TIMEOUT) ? MAX_HG : ACK_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [2:0]       LAST_IDX  = 3'(NSTAGES - 1);

    localparam logic [2:0] S_HOLD     = 3'd0;
    localparam logic [2:0] S_WAIT_ACK = 3'd1;
    localparam logic [2:0] S_GAP      = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_FAULT    = 3'd4;

    logic [2:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [NSTAGES-1:0] r_stage_reset;
    logic               r_resetting;
    logic               r_fault;
    logic [2:0]         r_stage_idx;

    logic [2:0]         w_state;
    logic [CNT_W-1:0]   w_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [NSTAGES-1:0] w_stage_reset;
    logic               w_resetting;
    logic               w_fault;
    logic [2:0]         w_stage_idx;
    logic [2:0]         w_idx_plus1;
    logic               w_ack_cur;
    logic [NSTAGES-1:0] w_next_mask;

    // Ack of the current stage and one-hot of the stage released next.
    always_comb begin
        w_ack_cur   = 1'b0;
        w_next_mask = '0;
        w_idx_plus1 = r_stage_idx + 3'd1;
        for (int i = 0; i < int'(NSTAGES); i++) begin
            if (r_stage_idx == 3'(i)) begin
                w_ack_cur = stage_ack[i];
            end
            w_next_mask[i] = (w_idx_plus1 == 3'(i));
        end
    end

    assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);

    // Next-state and next-output logic.
    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_stage_reset = r_stage_reset;
        w_resetting   = r_resetting;
        w_fault       = r_fault;
        w_stage_idx   = r_stage_idx;

        case (r_state)
            S_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state          = S_WAIT_ACK;
                    w_cnt            = '0;
                    w_stage_reset[0] = 1'b0;
                end else begin
                    w_cnt = w_cnt_inc;
                end
            end
            S_WAIT_ACK: begin
                // An ack on the timeout edge itself still counts.
                if (w_ack_cur) begin
                    w_cnt = '0;
                    if (r_stage_idx == LAST_IDX) begin
                        w_state       = S_RUN;
                        w_stage_reset = '0;
                        w_resetting   = 1'b0;
                    end else begin
                        w_state = S_GAP;
                    end
                end else if (r_cnt == ACK_LAST) begin
                    w_state       = S_FAULT;
                    w_cnt         = '0;
                    w_stage_reset = '1;
                    w_resetting   = 1'b1;
                    w_fault       = 1'b1;
                end else begin
                    w_cnt = w_cnt_inc;
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state       = S_WAIT_ACK;
                    w_cnt         = '0;
                    w_stage_idx   = w_idx_plus1;
                    w_stage_reset = r_stage_reset & ~w_next_mask;
                end else begin
                    w_cnt = w_cnt_inc;
                end
            end
            S_RUN: begin
                w_stage_reset = '0;
                w_resetting   = 1'b0;
            end
            S_FAULT: begin
                w_stage_reset = '1;
                w_resetting   = 1'b1;
                w_fault       = 1'b1;
            end
            default: begin
                w_state       = S_HOLD;
                w_cnt         = '0;
                w_stage_reset = '1;
                w_resetting   = 1'b1;
                w_stage_idx   = 3'd0;
            end
        endcase

        // Software reset restarts the sequence from anywhere except FAULT.
        if (swreset_req && (r_state != S_FAULT)) begin
            w_state       = S_HOLD;
            w_cnt         = '0;
            w_stage_reset = '1;
            w_resetting   = 1'b1;
            w_stage_idx   = 3'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_HOLD;
            r_cnt         <= '0;
            r_stage_reset <= '1;
            r_resetting   <= 1'b1;
            r_fault       <= 1'b0;
            r_stage_idx   <= 3'd0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_stage_reset <= w_stage_reset;
            r_resetting   <= w_resetting;
            r_fault       <= w_fault;
            r_stage_idx   <= w_stage_idx;
        end
    end

    assign stage_reset = r_stage_reset;
    assign resetting   = r_resetting;
    assign fault       = r_fault;
    assign stage_idx   = r_stage_idx;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-up sequence, ack timeout, software reset,
// asynchronous reset mid-sequence and ack on the timeout edge.
`timescale 1ns/1ps

module tb_reset_sequencer;

    logic       clk;
    logic       reset;
    logic       swreset_req;
    logic [3:0] stage_ack;
    logic [3:0] stage_reset;
    logic       resetting;
    logic       fault;
    logic [2:0] stage_idx;

    int vectors;
    int miscompares;

    reset_sequencer #(
        .NSTAGES    (4),
        .HOLD_CYCLES(16),
        .STAGE_GAP  (8),
        .ACK_TIMEOUT(255)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .swreset_req(swreset_req),
        .stage_ack  (stage_ack),
        .stage_reset(stage_reset),
        .resetting  (resetting),
        .fault      (fault),
        .stage_idx  (stage_idx)
    );

    initial clk = 1'b0;
    always #125 clk = ~clk;

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] exp_sr, input logic exp_rs,
                       input logic exp_fl, input logic [2:0] exp_idx);
        vectors++;
        assert (stage_reset === exp_sr) else begin
            miscompares++;
            $error("FAIL %s stage_reset: observed %b expected %b", tag, stage_reset, exp_sr);
        end
        vectors++;
        assert (resetting === exp_rs) else begin
            miscompares++;
            $error("FAIL %s resetting: observed %b expected %b", tag, resetting, exp_rs);
        end
        vectors++;
        assert (fault === exp_fl) else begin
            miscompares++;
            $error("FAIL %s fault: observed %b expected %b", tag, fault, exp_fl);
        end
        vectors++;
        assert (stage_idx === exp_idx) else begin
            miscompares++;
            $error("FAIL %s stage_idx: observed %0d expected %0d", tag, stage_idx, exp_idx);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        swreset_req = 1'b0;
        stage_ack   = 4'b1111;

        // Power-up sequence
        #1000;
        chk("por", 4'b1111, 1'b1, 1'b0, 3'd0);
        #1000;
        reset = 1'b0;
        tick(15);
        chk("hold_15", 4'b1111, 1'b1, 1'b0, 3'd0);
        tick(1);
        chk("e0_rel0", 4'b1110, 1'b1, 1'b0, 3'd0);
        tick(8);
        chk("e0p8_gap", 4'b1110, 1'b1, 1'b0, 3'd0);
        tick(1);
        chk("e0p9_rel1", 4'b1100, 1'b1, 1'b0, 3'd1);
        tick(9);
        chk("e0p18_rel2", 4'b1000, 1'b1, 1'b0, 3'd2);
        tick(9);
        chk("e0p27_rel3", 4'b0000, 1'b1, 1'b0, 3'd3);
        tick(1);
        chk("e0p28_run", 4'b0000, 1'b0, 1'b0, 3'd3);
        stage_ack = 4'b0000;
        tick(3);
        chk("run_ack_ignored", 4'b0000, 1'b0, 1'b0, 3'd3);
        stage_ack = 4'b1111;

        // Software reset from RUN
        swreset_req = 1'b1;
        tick(1);
        swreset_req = 1'b0;
        chk("sw_edge", 4'b1111, 1'b1, 1'b0, 3'd0);
        tick(15);
        chk("sw_hold_15", 4'b1111, 1'b1, 1'b0, 3'd0);
        tick(1);
        chk("sw_rel0", 4'b1110, 1'b1, 1'b0, 3'd0);
        tick(9);
        chk("sw_rel1", 4'b1100, 1'b1, 1'b0, 3'd1);
        tick(9);
        chk("sw_rel2", 4'b1000, 1'b1, 1'b0, 3'd2);
        tick(9);
        chk("sw_rel3", 4'b0000, 1'b1, 1'b0, 3'd3);
        tick(1);
        chk("sw_run", 4'b0000, 1'b0, 1'b0, 3'd3);

        // Software reset re-requested on the 10th HOLD edge restarts the hold count
        swreset_req = 1'b1;
        tick(1);
        swreset_req = 1'b0;
        tick(9);
        chk("hold_9", 4'b1111, 1'b1, 1'b0, 3'd0);
        swreset_req = 1'b1;
        tick(1);
        swreset_req = 1'b0;
        chk("hold_req10", 4'b1111, 1'b1, 1'b0, 3'd0);
        tick(15);
        chk("hold_restart_15", 4'b1111, 1'b1, 1'b0, 3'd0);
        tick(1);
        chk("hold_restart_rel0", 4'b1110, 1'b1, 1'b0, 3'd0);

        // Missing ack on stage 2
        stage_ack = 4'b1011;
        tick(18);
        chk("miss_rel2", 4'b1000, 1'b1, 1'b0, 3'd2);
        tick(254);
        chk("miss_to_m1", 4'b1000, 1'b1, 1'b0, 3'd2);
        tick(1);
        chk("miss_fault", 4'b1111, 1'b1, 1'b1, 3'd2);
        swreset_req = 1'b1;
        tick(1);
        swreset_req = 1'b0;
        chk("fault_sw_ignored", 4'b1111, 1'b1, 1'b1, 3'd2);
        tick(20);
        chk("fault_sticky", 4'b1111, 1'b1, 1'b1, 3'd2);
        reset = 1'b1;
        #50;
        chk("fault_async_clr", 4'b1111, 1'b1, 1'b0, 3'd0);
        #50;
        reset = 1'b0;

        // Asynchronous reset in GAP after stage 1 ack
        stage_ack = 4'b1111;
        tick(16);
        chk("ar_rel0", 4'b1110, 1'b1, 1'b0, 3'd0);
        tick(9);
        chk("ar_rel1", 4'b1100, 1'b1, 1'b0, 3'd1);
        tick(2);
        chk("ar_in_gap", 4'b1100, 1'b1, 1'b0, 3'd1);
        #50;
        reset = 1'b1;
        #1;
        chk("ar_immediate", 4'b1111, 1'b1, 1'b0, 3'd0);
        #49;
        reset = 1'b0;

        // Stage 1 ack first sampled on the timeout edge
        stage_ack = 4'b1101;
        tick(16);
        chk("bnd_rel0", 4'b1110, 1'b1, 1'b0, 3'd0);
        tick(9);
        chk("bnd_rel1", 4'b1100, 1'b1, 1'b0, 3'd1);
        tick(254);
        chk("bnd_to_m1", 4'b1100, 1'b1, 1'b0, 3'd1);
        stage_ack = 4'b1111;
        tick(1);
        chk("bnd_ack_wins", 4'b1100, 1'b1, 1'b0, 3'd1);
        tick(7);
        chk("bnd_gap7", 4'b1100, 1'b1, 1'b0, 3'd1);
        tick(1);
        chk("bnd_rel2", 4'b1000, 1'b1, 1'b0, 3'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Staged reset controller placed after the board reset logic.
- Holds a set of downstream units (for example the microcode sequencer, bus interface and peripheral buses) in reset.
- After a minimum hold time, releases them one at a time in index order. Each stage must acknowledge readiness before the next stage is released.
- Also accepts a software reset request.
- Flags a sticky fault if a stage fails to acknowledge in time.

Parameters:
NSTAGES, 4, number of reset stages (1..8)
HOLD_CYCLES, 16, clocks that all stages stay in reset after reset release or swreset_req (>=1)
STAGE_GAP, 8, clocks between a stage's ack and the next stage's release (>=1)
ACK_TIMEOUT, 255, max clocks to wait for a stage ack before faulting (>=1)

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
swreset_req  input  1  software reset request, level-sampled on each clk edge
stage_ack  input  NSTAGES  per-stage ready; bit i is only observed while stage i is current
stage_reset  output  NSTAGES  per-stage reset, active-high
resetting  output  1  high unless the sequence has completed (state RUN)
fault  output  1  sticky ack-timeout flag
stage_idx  output  3  index of the stage currently being released or waited on

Behaviour:
- Reset (asynchronous, no clock edge needed):
  - stage_reset = all ones, resetting = 1, fault = 0, stage_idx = 0.
  - All counters cleared; state = HOLD.
  - Held in this condition while reset is high.
- States: HOLD, WAIT_ACK, GAP, RUN, FAULT.
- Counter width: $clog2(max(HOLD_CYCLES, STAGE_GAP, ACK_TIMEOUT) + 1). Counters saturate; they never wrap.
- HOLD:
  - The counter increments on each edge.
  - On the HOLD_CYCLES-th rising edge after reset deasserts, clear stage_reset[0] and enter WAIT_ACK with the timer at 0.
- WAIT_ACK:
  - Ack is sampled starting on the edge after the release edge. An ack that is already high at release is accepted at release+1.
  - On an edge where stage_ack[stage_idx] = 1:
    - If stage_idx = NSTAGES-1: enter RUN; resetting falls on that edge.
    - Otherwise: enter GAP.
  - If no ack by the ACK_TIMEOUT-th edge after the release edge: on that edge enter FAULT.
  - If the ack arrives on the timeout edge itself, the ack wins.
- GAP:
  - After STAGE_GAP edges, increment stage_idx and clear stage_reset[stage_idx] on the same edge.
  - Then return to WAIT_ACK with the timer at 0.
- RUN:
  - stage_reset = 0 and resetting = 0.
  - Changes on stage_ack are ignored.
- FAULT:
  - stage_reset = all ones, resetting = 1, fault = 1.
  - stage_idx keeps the failing index.
  - swreset_req is ignored. Only reset exits this state.
- swreset_req = 1 at an edge in HOLD, WAIT_ACK, GAP or RUN:
  - On that edge: stage_reset = all ones, resetting = 1, stage_idx = 0, counters = 0, state = HOLD.
  - In HOLD this restarts the hold count.
  - fault is unchanged.
- Already-released stages are never re-asserted except by swreset_req, FAULT or reset.
- stage_reset bits are monotonic during a sequence: bit i clears only after bits 0..i-1 have cleared.

Test Plan:
1. Power-up: clk period 250 ns, reset high for 2000 ns then low, stage_ack tied 4'b1111, defaults.
   - Let E0 be the 16th edge after reset deasserts.
   - stage_reset steps 1111 -> 1110 @E0 -> 1100 @E0+9 -> 1000 @E0+18 -> 0000 @E0+27.
   - resetting falls @E0+28. fault = 0.
2. Missing ack: stage_ack[2] held 0.
   - 255 edges after stage 2 is released: stage_reset = 1111, resetting = 1, fault = 1, stage_idx = 2.
   - A swreset_req pulse then has no effect.
   - reset high for 100 ns clears fault to 0 asynchronously.
3. Software reset in RUN: one-cycle swreset_req.
   - On the sampling edge: stage_reset = 1111, stage_idx = 0.
   - The full sequence from scenario 1 repeats, relative to that edge. fault stays 0.
4. Asynchronous reset mid-GAP (after stage 1 ack), asserted between clock edges.
   - stage_reset = 1111, resetting = 1 and stage_idx = 0 immediately, before the next edge.
5. Boundary ack: stage 1 ack rises so that it is first sampled exactly on the 255th edge after release.
   - Enters GAP, fault = 0, and stage 2 is released 8 edges later.
6. swreset_req asserted on the 10th HOLD edge.
   - stage_reset[0] does not clear until 16 edges after the request edge.
